spec_ram_reader: RTL and testbench

Reader end of the learned-spectrum RAM pair (real and imag, 2800x16 each, 1-cycle read latency, enb-gated doutb).
- On start, sweeps addresses 0..DEPTH-1 and returns the paired words as a backpressured AXI-stream-style beat stream with index and last.
- Sits between the two spectrum RAMs (port B) and the downstream inverse-transform/compare logic, in the FFT clock domain.

---
 rtl/spec_ram_reader_pkg.sv | 21 ++
 rtl/spec_ram_reader_if.sv | 14 +
 rtl/spec_beat_fifo.sv | 79 +++++++
 rtl/spec_ram_reader.sv | 144 ++++++++++++++
 tb/tb_spec_ram_reader.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spec_ram_reader_pkg.sv
// Shared constants, FSM state type and beat layout for the spectrum RAM reader.
package spec_rd_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 2800;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  // Real word in the low bits, imag above it, source index on top.
  typedef struct packed {
    logic [ADDR_W-1:0] index;
    logic [DATA_W-1:0] imag_w;
    logic [DATA_W-1:0] real_w;
  } beat_t;

endpackage

// File: rtl/spec_ram_reader_if.sv
// Output beat stream of the spectrum RAM reader: {imag, real} data with index and last.
interface spec_ram_reader_if;
  import spec_rd_pkg::*;

  logic [2*DATA_W-1:0] tdata;
  logic                tvalid;
  logic                tready;
  logic                tlast;
  logic [ADDR_W-1:0]   index;

  modport master (output tdata, tvalid, tlast, index, input tready);
  modport slave  (input tdata, tvalid, tlast, index, output tready);

endinterface

// File: rtl/spec_beat_fifo.sv
// Small synchronous FIFO of spectrum beats; count feeds the reader's read-credit logic.
module spec_beat_fifo
  import spec_rd_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  beat_t                        wdata_i,
  output beat_t                        rdata_o,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  beat_t           mem_q [Depth];
  beat_t           mem_d [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full, do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full    = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The reader's credit rule must make a push into a full FIFO impossible.
  overflow_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full && !flush_i));

endmodule

// File: rtl/spec_ram_reader.sv
// Sweeps the real/imag spectrum RAMs and streams paired words out with credit-based flow control.
module spec_ram_reader
  import spec_rd_pkg::*;
#(
  parameter int unsigned Depth     = DEPTH,
  parameter int unsigned FifoDepth = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] real_addr,
  output logic [ADDR_W-1:0] imag_addr,
  input  logic [DATA_W-1:0] rd_real,
  input  logic [DATA_W-1:0] rd_imag,
  spec_ram_reader_if.master m_axis,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned       CntW     = $clog2(FifoDepth + 1);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(Depth - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] idx1_q, idx1_d;
  logic              rd_en_q, rd_en_d;
  logic              v1_q, v1_d;
  logic              cont_q, cont_d;
  logic              done_q, done_d;

  logic              fifo_empty, push, pop, credit_ok;
  logic [CntW-1:0]   fifo_count;
  logic [CntW:0]     used;
  beat_t             wr_beat, head;

  // Outstanding = queued beats + read on the RAM port + data on doutb.
  assign used      = (CntW+1)'(fifo_count) + (CntW+1)'(rd_en_q) + (CntW+1)'(v1_q);
  assign credit_ok = (32'(used) < FifoDepth);

  assign wr_beat = '{index: idx1_q, imag_w: rd_imag, real_w: rd_real};
  assign push    = v1_q && !stop;
  assign pop     = !fifo_empty && m_axis.tready;

  spec_beat_fifo #(
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (sys_clk),
    .rst_ni  (sys_rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (stop),
    .wdata_i (wr_beat),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cont_d  = cont_q;
    rd_en_d = 1'b0;
    addr_d  = cnt_q;
    v1_d    = rd_en_q;
    idx1_d  = addr_q;
    done_d  = pop && (head.index == LastAddr);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          cnt_d   = '0;
          cont_d  = continuous;
        end
      end
      StRun: begin
        if (credit_ok) begin
          rd_en_d = 1'b1;
          if (cnt_q == LastAddr) begin
            cnt_d = '0;
            if (!cont_q) begin
              state_d = StDrain;
            end
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      StDrain: begin
        if (!rd_en_q && !v1_q && fifo_empty) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Stop wins over everything, including a simultaneous start.
    if (stop) begin
      state_d = StIdle;
      cnt_d   = '0;
      rd_en_d = 1'b0;
      addr_d  = '0;
      v1_d    = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      idx1_q  <= '0;
      rd_en_q <= 1'b0;
      v1_q    <= 1'b0;
      cont_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      idx1_q  <= idx1_d;
      rd_en_q <= rd_en_d;
      v1_q    <= v1_d;
      cont_q  <= cont_d;
      done_q  <= done_d;
    end
  end

  assign ram_rd_en  = rd_en_q;
  assign real_addr  = addr_q;
  assign imag_addr  = addr_q;
  assign busy       = (state_q != StIdle);
  assign frame_done = done_q;

  assign m_axis.tvalid = !fifo_empty;
  assign m_axis.tdata  = {head.imag_w, head.real_w};
  assign m_axis.index  = head.index;
  assign m_axis.tlast  = !fifo_empty && (head.index == LastAddr);

endmodule

// File: tb/tb_spec_ram_reader.sv
// Scoreboard bench for spec_ram_reader: RAM model, expected-beat queue and a negedge monitor.
module tb_spec_ram_reader;
  import spec_rd_pkg::*;

  localparam int FD = 4;
  localparam int D  = DEPTH;

  logic              sys_clk, sys_rst_n, start, stop, continuous;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] real_addr, imag_addr;
  logic [DATA_W-1:0] rd_real, rd_imag;
  logic              busy, frame_done;

  spec_ram_reader_if m_axis ();

  spec_ram_reader #(
    .Depth     (D),
    .FifoDepth (FD)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .ram_rd_en  (ram_rd_en),
    .real_addr  (real_addr),
    .imag_addr  (imag_addr),
    .rd_real    (rd_real),
    .rd_imag    (rd_imag),
    .m_axis     (m_axis),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Spectrum RAM pair: one-cycle latency, doutb only updates when enb is high.
  logic [DATA_W-1:0] ram_re [D];
  logic [DATA_W-1:0] ram_im [D];
  always @(posedge sys_clk) begin
    if (ram_rd_en && int'(real_addr) < D && int'(imag_addr) < D) begin
      rd_real <= ram_re[int'(real_addr)];
      rd_imag <= ram_im[int'(imag_addr)];
    end
  end

  typedef struct {
    int                  idx;
    logic [2*DATA_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   total, bad;
  int   outstanding, done_count, last_idx, cyc, last_hs_cyc, rdy_mode;
  bit   done_pend, stall_pend, gapless;
  logic [2*DATA_W-1:0] stall_data;
  logic [ADDR_W-1:0]   stall_idx;

  task automatic check(input string name, input longint act, input longint want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, want, $time);
    end
  endtask

  // Downstream ready: 0 = hold low, 1 = hold high, 2 = random 50%.
  initial begin
    m_axis.tready = 1'b0;
    forever begin
      @(posedge sys_clk);
      #1;
      m_axis.tready = (rdy_mode == 2) ? 1'($urandom_range(1, 0)) : (rdy_mode == 1);
    end
  end

  // Monitor: every handshake pops the scoreboard; also frame_done, stalls and read credit.
  initial begin : monitor
    exp_t e;
    bit   hs;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        outstanding = 0;
        done_pend   = 1'b0;
        stall_pend  = 1'b0;
      end else begin
        hs = m_axis.tvalid && m_axis.tready;
        check("frame_done", frame_done, done_pend);
        if (frame_done) done_count++;
        if (stall_pend) begin
          check("stall_valid", m_axis.tvalid, 1);
          check("stall_data", m_axis.tdata, stall_data);
          check("stall_index", m_axis.index, stall_idx);
        end
        if (ram_rd_en) begin
          check("addr_range", int'(real_addr) < D, 1);
          check("addr_pair", imag_addr, real_addr);
        end
        done_pend = 1'b0;
        if (hs) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", m_axis.index, -1);
          end else begin
            e = exp_q.pop_front();
            check("beat_index", m_axis.index, e.idx);
            check("beat_data", m_axis.tdata, e.data);
            check("beat_last", m_axis.tlast, e.idx == D - 1);
            if (gapless && last_hs_cyc >= 0) check("beat_gap", cyc - last_hs_cyc, 1);
            last_hs_cyc = cyc;
            last_idx    = e.idx;
            done_pend   = (e.idx == D - 1);
          end
        end
        outstanding += int'(ram_rd_en);
        check("credit", outstanding <= FD, 1);
        if (hs) outstanding--;
        if (stop) outstanding = 0;
        stall_pend = m_axis.tvalid && !m_axis.tready && !stop;
        stall_data = m_axis.tdata;
        stall_idx  = m_axis.index;
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic fill_ram(input bit rnd);
    for (int i = 0; i < D; i++) begin
      ram_re[i] = rnd ? DATA_W'($urandom) : DATA_W'(i);
      ram_im[i] = rnd ? DATA_W'($urandom) : ~DATA_W'(i);
    end
  endtask

  task automatic push_frames(input int n);
    for (int f = 0; f < n; f++) begin
      for (int i = 0; i < D; i++) exp_q.push_back('{i, {ram_im[i], ram_re[i]}});
    end
  endtask

  task automatic pulse_start(input bit cont);
    continuous = cont;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    check({name, "_idle"}, busy, 0);
  endtask

  task automatic wait_idx(input string name, input int target, input int budget);
    int n = 0;
    while (last_idx < target && n < budget) begin
      step();
      n++;
    end
    check({name, "_reach_idx"}, last_idx >= target, 1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_rd_en"}, ram_rd_en, 0);
    check({name, "_real_addr"}, real_addr, 0);
    check({name, "_imag_addr"}, imag_addr, 0);
    check({name, "_tvalid"}, m_axis.tvalid, 0);
    check({name, "_tdata"}, m_axis.tdata, 0);
    check({name, "_tlast"}, m_axis.tlast, 0);
    check({name, "_index"}, m_axis.index, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_frame_done"}, frame_done, 0);
  endtask

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int  n;
    bit  got;
    total = 0; bad = 0; outstanding = 0; done_count = 0; last_idx = -1;
    cyc = 0; last_hs_cyc = -1; rdy_mode = 1;
    done_pend = 1'b0; stall_pend = 1'b0; gapless = 1'b0;
    sys_rst_n = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    fill_ram(1'b0);
    #12;
    check_all_zero("reset");
    step();
    sys_rst_n = 1'b1;
    step();
    step();

    // 1: single frame, full throughput, first beat three edges after start.
    push_frames(1);
    last_hs_cyc = -1; gapless = 1'b1; done_count = 0; last_idx = -1;
    pulse_start(1'b0);
    n = 0; got = 1'b0;
    while (!got && n < 10) begin
      @(negedge sys_clk);
      #1;
      if (n == 1) begin
        check("t1_first_rd_en", ram_rd_en, 1);
        check("t1_first_addr", real_addr, 0);
      end
      if (m_axis.tvalid) got = 1'b1;
      else n++;
    end
    check("t1_first_beat_latency", n, 3);
    wait_idle("t1", 3000);
    step();
    gapless = 1'b0;
    check("t1_left", exp_q.size(), 0);
    check("t1_done_count", done_count, 1);
    check("t1_rd_en_after", ram_rd_en, 0);
    check("t1_addr_after", real_addr, 0);

    // 2: random backpressure.
    rdy_mode = 2;
    push_frames(1);
    pulse_start(1'b0);
    wait_idle("t2", 20000);
    rdy_mode = 1;
    step();
    check("t2_left", exp_q.size(), 0);

    // 3: continuous frames wrap with no gap; mid-run continuous change ignored; then stop.
    push_frames(4);
    last_hs_cyc = -1; gapless = 1'b1; done_count = 0;
    pulse_start(1'b1);
    continuous = 1'b0;
    n = 0;
    while (done_count < 3 && n < 9000) begin
      step();
      n++;
    end
    check("t3_three_frames", done_count, 3);
    pulse_stop();
    gapless = 1'b0;
    check("t3_tvalid_after_stop", m_axis.tvalid, 0);
    check("t3_busy_after_stop", busy, 0);
    repeat (5) step();
    check("t3_done_count_final", done_count, 3);

    // 4: stop with a full, stalled FIFO, then a clean restart.
    fill_ram(1'b1);
    push_frames(1);
    last_idx = -1;
    pulse_start(1'b0);
    wait_idx("t4", 999, 2000);
    rdy_mode = 0;
    repeat (10) step();
    check("t4_stalled_valid", m_axis.tvalid, 1);
    check("t4_outstanding_full", outstanding, FD);
    pulse_stop();
    check("t4_tvalid_after_stop", m_axis.tvalid, 0);
    check("t4_busy_after_stop", busy, 0);
    rdy_mode = 1;
    repeat (10) step();
    check("t4_no_stale", m_axis.tvalid, 0);
    push_frames(1);
    last_hs_cyc = -1; gapless = 1'b1;
    pulse_start(1'b0);
    wait_idle("t4b", 3000);
    step();
    gapless = 1'b0;
    check("t4_left", exp_q.size(), 0);

    // 5: start while busy is ignored; start+stop together while idle stays idle.
    fill_ram(1'b1);
    push_frames(1);
    last_idx = -1;
    pulse_start(1'b0);
    wait_idx("t5", 500, 2000);
    pulse_start(1'b1);
    check("t5_busy_after_restart", busy, 1);
    wait_idle("t5", 3000);
    step();
    check("t5_left", exp_q.size(), 0);
    continuous = 1'b0;
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check("t5_busy_startstop", busy, 0);
    repeat (5) step();
    check("t5_busy_later", busy, 0);
    check("t5_rd_en_later", ram_rd_en, 0);

    // 6: asynchronous reset mid-frame, then a clean frame.
    push_frames(1);
    last_idx = -1;
    pulse_start(1'b0);
    wait_idx("t6", 1500, 3000);
    sys_rst_n = 1'b0;
    #1;
    check_all_zero("t6_reset");
    exp_q.delete();
    repeat (3) step();
    check_all_zero("t6_reset_held");
    sys_rst_n = 1'b1;
    step();
    fill_ram(1'b1);
    push_frames(1);
    last_hs_cyc = -1; gapless = 1'b1;
    pulse_start(1'b0);
    wait_idle("t6b", 3000);
    step();
    gapless = 1'b0;
    check("t6_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
